// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the two-digit scan scheduler.
// The optional macro SEG_SCAN_LEADING_ZERO_BLANK_EN is consumed by seg_scan_scheduler.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        SHOW0  = 2'd0,
        BLANK0 = 2'd1,
        SHOW1  = 2'd2,
        BLANK1 = 2'd3
    } scan_state_t;

    localparam logic [1:0] EN_OFF = 2'b11;
    localparam logic [1:0] EN_D0  = 2'b10;
    localparam logic [1:0] EN_D1  = 2'b01;

    // Width needed to count 0..max(a,b)-1; kept at least 1 bit so a 1-cycle phase still builds.
    function automatic int cnt_width(input int a, input int b);
        if (a >= b) begin
            return (a > 1) ? $clog2(a) : 1;
        end
        return (b > 1) ? $clog2(b) : 1;
    endfunction

endpackage

// File: rtl/seg_phase_counter.sv
// Phase timer: counts 0..last and raises done while the count sits at last,
// then restarts from 0 on the following edge (the FSM changes state on that same edge).
module seg_phase_counter #(
    parameter int CNT_W = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] last,
    output logic             done
);

    logic [CNT_W-1:0] count;

    assign done = (count == last);

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (done) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Time-multiplexes two hex digits onto a shared 7-segment decoder with blanking dead time.
// Build option: define SEG_SCAN_LEADING_ZERO_BLANK_EN to keep digit 1 dark while it holds 0.
module seg_scan_scheduler #(
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] digit0_in,
    input  logic [3:0] digit1_in,
    output logic       load_ack,
    output logic [3:0] s_out,
    output logic [1:0] en_n,
    output logic       frame_tick
);

    import seg_scan_pkg::*;

    localparam int CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      state, state_next;
    logic [CNT_W-1:0] phase_last;
    logic             phase_done;

    logic [3:0] shadow0, shadow1, shadow0_next, shadow1_next;
    logic [3:0] pend0, pend1, pend0_next, pend1_next;
    logic       pend_flag, pend_flag_next;
    logic [1:0] en_next;
    logic [3:0] s_next;
    logic       ack_next, tick_next, commit;

    assign phase_last = (state == SHOW0 || state == SHOW1) ? DWELL_LAST : BLANK_LAST;

    seg_phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clk   (clk),
        .reset (reset),
        .last  (phase_last),
        .done  (phase_done)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        commit         = 1'b0;
        tick_next      = 1'b0;
        shadow0_next   = shadow0;
        shadow1_next   = shadow1;
        pend0_next     = pend0;
        pend1_next     = pend1;
        pend_flag_next = pend_flag;
        en_next        = EN_OFF;
        s_next         = s_out;

        if (phase_done) begin
            case (state)
                SHOW0:   state_next = BLANK0;
                BLANK0:  state_next = SHOW1;
                SHOW1:   state_next = BLANK1;
                default: begin
                    state_next = SHOW0;
                    tick_next  = 1'b1;
                    commit     = pend_flag | load;
                end
            endcase
        end

        // A load landing on the frame edge bypasses the pending registers.
        if (commit) begin
            shadow0_next   = load ? digit0_in : pend0;
            shadow1_next   = load ? digit1_in : pend1;
            pend_flag_next = 1'b0;
        end else if (load) begin
            pend0_next     = digit0_in;
            pend1_next     = digit1_in;
            pend_flag_next = 1'b1;
        end
        ack_next = commit;

        // Outputs follow the next state so they change on the same edge as the state register.
        case (state_next)
            SHOW0: begin
                en_next = EN_D0;
                s_next  = shadow0_next;
            end
            SHOW1: begin
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
                en_next = (shadow1_next == 4'h0) ? EN_OFF : EN_D1;
`else
                en_next = EN_D1;
`endif
                s_next  = shadow1_next;
            end
            default: en_next = EN_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK1;
            en_n       <= EN_OFF;
            s_out      <= 4'h0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
            shadow0    <= 4'h0;
            shadow1    <= 4'h0;
            pend0      <= 4'h0;
            pend1      <= 4'h0;
            pend_flag  <= 1'b0;
        end else begin
            state      <= state_next;
            en_n       <= en_next;
            s_out      <= s_next;
            load_ack   <= ack_next;
            frame_tick <= tick_next;
            shadow0    <= shadow0_next;
            shadow1    <= shadow1_next;
            pend0      <= pend0_next;
            pend1      <= pend1_next;
            pend_flag  <= pend_flag_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler with DWELL_CYCLES=4, BLANK_CYCLES=2 (frame = 12 cycles).
module tb_seg_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] digit0_in, digit1_in;
    logic       load_ack;
    logic [3:0] s_out;
    logic [1:0] en_n;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    // cyc 0 is the sample taken right after the last reset edge; frames begin at cyc 2, 14, 26...
    int         cyc;
    int         ack_at;
    logic [3:0] m0, m1, n0, n1, ms;

    seg_scan_scheduler #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digit0_in  (digit0_in),
        .digit1_in  (digit1_in),
        .load_ack   (load_ack),
        .s_out      (s_out),
        .en_n       (en_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (cyc %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_en_n", 8'(en_n), 8'h03);
        check("rst_s_out", 8'(s_out), 8'h00);
        check("rst_ack", 8'(load_ack), 8'h00);
        check("rst_tick", 8'(frame_tick), 8'h00);
    endtask

    // Drive one cycle of inputs, clock once, then check all outputs against the frame model.
    task automatic adv(input logic ld, input logic [3:0] a, input logic [3:0] b);
        int         p;
        logic [1:0] exp_en;
        load      = ld;
        digit0_in = a;
        digit1_in = b;
        @(posedge clk);
        #1;
        load = 1'b0;
        cyc++;
        p = (cyc >= 2) ? (cyc - 2) % 12 : 10;
        if (cyc == ack_at) begin
            m0 = n0;
            m1 = n1;
        end
        if (p < 4) begin
            exp_en = 2'b10;
            ms     = m0;
        end else if (p >= 6 && p < 10) begin
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            exp_en = (m1 == 4'h0) ? 2'b11 : 2'b01;
`else
            exp_en = 2'b01;
`endif
            ms     = m1;
        end else begin
            exp_en = 2'b11;
        end
        check("en_n", 8'(en_n), 8'(exp_en));
        check("s_out", 8'(s_out), 8'(ms));
        check("frame_tick", 8'(frame_tick), 8'(cyc >= 2 && p == 0));
        check("load_ack", 8'(load_ack), 8'(cyc == ack_at));
    endtask

    task automatic idle_until(input int last_cyc);
        while (cyc < last_cyc) adv(1'b0, 4'h0, 4'h0);
    endtask

    initial begin
        reset = 1'b1;
        load = 1'b0;
        digit0_in = 4'h0;
        digit1_in = 4'h0;
        cyc = 0;
        ack_at = -1;
        m0 = 4'h0; m1 = 4'h0; n0 = 4'h0; n1 = 4'h0; ms = 4'h0;

        // Reset, then two full frames of the idle scan pattern.
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outputs();
        idle_until(23);

        // Load during SHOW1: nothing moves until the boundary at cyc 26.
        ack_at = 26; n0 = 4'h3; n1 = 4'hA;
        adv(1'b1, 4'h3, 4'hA);
        idle_until(38);

        // Two loads before commit: last wins, single ack at cyc 50.
        adv(1'b1, 4'h1, 4'h2);
        idle_until(41);
        ack_at = 50; n0 = 4'h5; n1 = 4'h6;
        adv(1'b1, 4'h5, 4'h6);
        idle_until(62);

        // Load exactly on the commit edge (edge producing cyc 74) bypasses pending.
        idle_until(73);
        ack_at = 74; n0 = 4'hF; n1 = 4'hE;
        adv(1'b1, 4'hF, 4'hE);
        idle_until(86);

        // Reset mid-SHOW0 with a load pending: pending is discarded, no ack ever.
        adv(1'b1, 4'h9, 4'h8);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outputs();
        cyc = 0; ack_at = -1;
        m0 = 4'h0; m1 = 4'h0; ms = 4'h0;
        idle_until(26);

        // Digit 1 committed as zero: blanked only when leading-zero suppression is built in.
        ack_at = 38; n0 = 4'h7; n1 = 4'h0;
        adv(1'b1, 4'h7, 4'h0);
        idle_until(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
